// File: rtl/proc_pkg.sv
// Shared processor constants: architectural register numbers, word width
// and the status codes the writeback stage deposits into rstatus (r30).
package proc_pkg;

   localparam int WORD_W = 32;

   localparam logic [4:0] REG_ZERO   = 5'd0;
   localparam logic [4:0] REG_STATUS = 5'd30;
   localparam logic [4:0] REG_RA     = 5'd31;

   typedef enum logic [31:0] {
      STATUS_NONE     = 32'd0,
      STATUS_ADD_OVF  = 32'd1,
      STATUS_ADDI_OVF = 32'd2,
      STATUS_SUB_OVF  = 32'd3,
      STATUS_MUL_OVF  = 32'd4,
      STATUS_DIV_ZERO = 32'd5
   } status_code_e;

endpackage

// File: rtl/regfile_bypass_if.sv
// Writeback write ports and decode read ports of the register file.
// No handshake: every strobe is taken in the cycle it is presented.
interface regfile_bypass_if #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 5
);

   logic             ctrl_writeEnable;
   logic [SEL_W-1:0] ctrl_writeReg;
   logic [WIDTH-1:0] data_writeReg;
   logic             ctrl_writeStatus;
   logic [WIDTH-1:0] data_writeStatusReg;
   logic [SEL_W-1:0] ctrl_readRegA;
   logic [SEL_W-1:0] ctrl_readRegB;
   logic [WIDTH-1:0] data_readRegA;
   logic [WIDTH-1:0] data_readRegB;

   modport master (
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      output ctrl_writeStatus, data_writeStatusReg,
      output ctrl_readRegA, ctrl_readRegB,
      input  data_readRegA, data_readRegB
   );

   modport slave (
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
      input  ctrl_writeStatus, data_writeStatusReg,
      input  ctrl_readRegA, ctrl_readRegB,
      output data_readRegA, data_readRegB
   );

endinterface

// File: rtl/register32.sv
// Single WIDTH-bit storage register with write enable and async active-low clear.
module register32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      data_d = data_q;
      if (we) data_d = d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: rtl/regfile_bypass.sv
// 32-entry architectural register file with same-cycle write-to-read bypass;
// r0 reads zero, r30 doubles as the status register.
module regfile_bypass
   import proc_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int NREGS = 32
) (
   input  logic             clock,
   input  logic             ctrl_reset_n,
   regfile_bypass_if.slave  rf
);

   localparam int SEL_W = $clog2(NREGS);

   // Single qualification shared by the commit enables and the bypass compare,
   // so a forwarded value always equals what lands in storage.
   logic gen_we;
   assign gen_we = rf.ctrl_writeEnable && (rf.ctrl_writeReg != REG_ZERO);

   logic [WIDTH-1:0] regs [NREGS];
   assign regs[0] = '0;

   genvar i;
   generate
      for (i = 1; i < NREGS; i++) begin : g_reg
         logic             we;
         logic [WIDTH-1:0] d;
         if (i == int'(REG_STATUS)) begin : g_status
            assign we = (gen_we && (rf.ctrl_writeReg == SEL_W'(i))) || rf.ctrl_writeStatus;
            assign d  = rf.ctrl_writeStatus ? rf.data_writeStatusReg : rf.data_writeReg;
         end else begin : g_gen
            assign we = gen_we && (rf.ctrl_writeReg == SEL_W'(i));
            assign d  = rf.data_writeReg;
         end
         register32 #(.WIDTH(WIDTH)) u_reg (
            .clk   (clock),
            .rst_n (ctrl_reset_n),
            .we    (we),
            .d     (d),
            .q     (regs[i])
         );
      end
   endgenerate

   function automatic logic [WIDTH-1:0] read_port(
      input logic [SEL_W-1:0] sel,
      input logic [WIDTH-1:0] stored,
      input logic             status_we,
      input logic [WIDTH-1:0] status_data,
      input logic             write_we,
      input logic [SEL_W-1:0] write_sel,
      input logic [WIDTH-1:0] write_data
   );
      logic [WIDTH-1:0] r;
      r = stored;
      if (sel == REG_ZERO)                    r = '0;
      else if (sel == REG_STATUS && status_we) r = status_data;
      else if (write_we && sel == write_sel)  r = write_data;
      return r;
   endfunction

   always_comb begin
      rf.data_readRegA = read_port(rf.ctrl_readRegA, regs[rf.ctrl_readRegA],
                                   rf.ctrl_writeStatus, rf.data_writeStatusReg,
                                   gen_we, rf.ctrl_writeReg, rf.data_writeReg);
      rf.data_readRegB = read_port(rf.ctrl_readRegB, regs[rf.ctrl_readRegB],
                                   rf.ctrl_writeStatus, rf.data_writeStatusReg,
                                   gen_we, rf.ctrl_writeReg, rf.data_writeReg);
   end

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: directed scenarios with literal expected values,
// then a randomized sweep against a reference model of the read priority.
module tb_regfile_bypass;

   logic clock;
   logic ctrl_reset_n;

   regfile_bypass_if #(.WIDTH(32), .SEL_W(5)) rf_if ();

   regfile_bypass #(.WIDTH(32), .NREGS(32)) dut (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .rf           (rf_if)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] mem [32];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // driver
   task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic ws, input logic [31:0] sd,
                        input logic [4:0] ra, input logic [4:0] rb);
      rf_if.ctrl_writeEnable    = we;
      rf_if.ctrl_writeReg       = wr;
      rf_if.data_writeReg       = wd;
      rf_if.ctrl_writeStatus    = ws;
      rf_if.data_writeStatusReg = sd;
      rf_if.ctrl_readRegA       = ra;
      rf_if.ctrl_readRegB       = rb;
   endtask

   task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, ra, rb);
   endtask

   // reference model
   function automatic logic [31:0] model_read(input logic [4:0] sel);
      if (sel == 5'd0) return 32'h0;
      if (sel == 5'd30 && rf_if.ctrl_writeStatus) return rf_if.data_writeStatusReg;
      if (rf_if.ctrl_writeEnable && sel == rf_if.ctrl_writeReg) return rf_if.data_writeReg;
      return mem[sel];
   endfunction

   // Advance one edge; the model commits only when reset is high at the edge.
   task automatic tick();
      @(posedge clock);
      if (ctrl_reset_n) begin
         if (rf_if.ctrl_writeEnable && rf_if.ctrl_writeReg != 5'd0)
            mem[rf_if.ctrl_writeReg] = rf_if.data_writeReg;
         if (rf_if.ctrl_writeStatus)
            mem[30] = rf_if.data_writeStatusReg;
      end
      #1;
   endtask

   initial begin
      logic        we, ws;
      logic [4:0]  wr, ra, rb;
      logic [31:0] wd, sd;

      for (int k = 0; k < 32; k++) mem[k] = 32'h0;
      ctrl_reset_n = 1'b0;
      idle(5'd5, 5'd31);
      repeat (2) @(posedge clock);
      #1;
      check("reset_state_a", rf_if.data_readRegA, 32'h0);
      check("reset_state_b", rf_if.data_readRegB, 32'h0);
      ctrl_reset_n = 1'b1;

      // reset: async clear, bypass live, write during reset lost
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 5'd5, 5'd0);
      #2 check("rst_pre_bypass", rf_if.data_readRegA, 32'hDEADBEEF);
      tick();
      idle(5'd5, 5'd0);
      #2 check("rst_pre_stored", rf_if.data_readRegA, 32'hDEADBEEF);
      ctrl_reset_n = 1'b0;
      for (int k = 0; k < 32; k++) mem[k] = 32'h0;
      #1 check("rst_async_clear", rf_if.data_readRegA, 32'h0);
      drive(1'b1, 5'd5, 32'h00000055, 1'b0, 32'h0, 5'd5, 5'd0);
      #1 check("rst_bypass_live", rf_if.data_readRegA, 32'h00000055);
      tick();
      idle(5'd5, 5'd0);
      #1 check("rst_write_lost", rf_if.data_readRegA, 32'h0);
      ctrl_reset_n = 1'b1;
      #1 check("rst_release", rf_if.data_readRegA, 32'h0);
      tick();
      #1 check("rst_after_edge", rf_if.data_readRegA, 32'h0);

      // r0 hardwired
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0, 5'd0, 5'd0);
      #2 check("r0_same_a", rf_if.data_readRegA, 32'h0);
      check("r0_same_b", rf_if.data_readRegB, 32'h0);
      tick();
      idle(5'd0, 5'd0);
      #2 check("r0_later_a", rf_if.data_readRegA, 32'h0);
      check("r0_later_b", rf_if.data_readRegB, 32'h0);
      tick();

      // bypass on r7
      drive(1'b1, 5'd7, 32'h12345678, 1'b0, 32'h0, 5'd0, 5'd7);
      #2 check("byp_same_b", rf_if.data_readRegB, 32'h12345678);
      tick();
      idle(5'd7, 5'd7);
      #2 check("byp_stored_a", rf_if.data_readRegA, 32'h12345678);
      check("byp_stored_b", rf_if.data_readRegB, 32'h12345678);
      tick();

      // r30 collision: status wins
      drive(1'b1, 5'd30, 32'h00000011, 1'b1, 32'h00000001, 5'd30, 5'd30);
      #2 check("coll_byp_a", rf_if.data_readRegA, 32'h00000001);
      check("coll_byp_b", rf_if.data_readRegB, 32'h00000001);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd30, 5'd0);
      #2 check("coll_stored", rf_if.data_readRegA, 32'h00000001);
      drive(1'b1, 5'd30, 32'h00000022, 1'b0, 32'h0, 5'd30, 5'd0);
      #1 check("gen30_byp", rf_if.data_readRegA, 32'h00000022);
      tick();
      idle(5'd30, 5'd0);
      #2 check("gen30_stored", rf_if.data_readRegA, 32'h00000022);
      tick();

      // dual write r31 + r30
      drive(1'b1, 5'd31, 32'h00000104, 1'b1, 32'h0000ABCD, 5'd31, 5'd30);
      #2 check("dual_byp_a", rf_if.data_readRegA, 32'h00000104);
      check("dual_byp_b", rf_if.data_readRegB, 32'h0000ABCD);
      tick();
      idle(5'd31, 5'd30);
      #2 check("dual_stored_a", rf_if.data_readRegA, 32'h00000104);
      check("dual_stored_b", rf_if.data_readRegB, 32'h0000ABCD);
      idle(5'd7, 5'd5);
      #1 check("retain_r7", rf_if.data_readRegA, 32'h12345678);
      check("retain_r5", rf_if.data_readRegB, 32'h0);
      tick();

      // random sweep, biased toward r30 collisions and select==destination
      for (int c = 0; c < 10000; c++) begin
         we = ($urandom_range(0, 1) == 1);
         ws = ($urandom_range(0, 3) == 0);
         wr = ($urandom_range(0, 7) == 0) ? 5'd30 : 5'($urandom_range(0, 31));
         wd = $urandom;
         sd = $urandom;
         ra = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         rb = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         drive(we, wr, wd, ws, sd, ra, rb);
         #2;
         check("rand_a", rf_if.data_readRegA, model_read(ra));
         check("rand_b", rf_if.data_readRegB, model_read(rb));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
